// File: rtl/bp_pkg.sv
// Shared definitions for the BP reconstruction controller.
//   state_t     : controller FSM states
//   cmd_t       : one reconstruction command (component, subblock, partition, skip)
//   CMDS_FULL   : commands per non-skip block (3 components x 4 subblocks)
//   CMDS_SKIP   : commands per BP-skip block (one per component)
//   cmd_fields(): maps a command index within a block to its cmd_t fields
package bp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int CMDS_FULL = 12;
    localparam int CMDS_SKIP = 3;

    localparam int COMP_W = 2;   // component index 0..2
    localparam int SB_W   = 2;   // subblock index 0..3
    localparam int SB_NUM = 4;   // subblocks per component
    localparam int QP_W   = 8;
    localparam int CNT_W  = 4;   // command index within a block, 0..11
    localparam int CRED_W = 2;   // outstanding commands, 0..3

    typedef struct packed {
        logic [COMP_W-1:0] comp;
        logic [SB_W-1:0]   sb;
        logic              part2x2;
        logic              skip;
    } cmd_t;

    // Non-skip blocks walk comp-major: idx[3:2] is the component and
    // idx[1:0] the subblock. Skip blocks use idx directly as the component.
    function automatic cmd_t cmd_fields(input logic              is_skip,
                                        input logic [CNT_W-1:0]  idx,
                                        input logic [SB_NUM-1:0] use2x2);
        cmd_t f;
        f = '0;
        if (is_skip) begin
            f.comp = idx[COMP_W-1:0];
        end else begin
            f.comp    = idx[3:2];
            f.sb      = idx[1:0];
            f.part2x2 = use2x2[idx[1:0]];
        end
        f.skip = is_skip;
        return f;
    endfunction

endpackage

// File: rtl/bp_rec_ctrl_if.sv
// Block-descriptor and command/completion signals of bp_rec_ctrl.
//   master : controller view (accepts descriptors, issues commands, sees rec_done)
//   slave  : environment view (supplies descriptors, consumes commands)
interface bp_rec_ctrl_if;
    import bp_pkg::*;

    logic              blk_valid;
    logic              blk_ready;
    logic              blk_bpskip;
    logic [SB_NUM-1:0] blk_use2x2;
    logic [QP_W-1:0]   blk_qp;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [COMP_W-1:0] cmd_comp;
    logic [SB_W-1:0]   cmd_sb;
    logic              cmd_2x2;
    logic              cmd_skip;
    logic [QP_W-1:0]   cmd_qp;

    logic              rec_done;

    modport master (
        input  blk_valid, blk_bpskip, blk_use2x2, blk_qp, cmd_ready, rec_done,
        output blk_ready, cmd_valid, cmd_comp, cmd_sb, cmd_2x2, cmd_skip, cmd_qp
    );

    modport slave (
        output blk_valid, blk_bpskip, blk_use2x2, blk_qp, cmd_ready, rec_done,
        input  blk_ready, cmd_valid, cmd_comp, cmd_sb, cmd_2x2, cmd_skip, cmd_qp
    );

endinterface

// File: rtl/bp_credit_cnt.sv
// Outstanding-command credit counter.
//   clk, rst  : clock, synchronous active-high reset
//   inc       : a command was accepted this cycle
//   dec       : a command completed this cycle
//   avail     : fewer than MAX_OUT commands outstanding
//   zero      : no commands outstanding
//   zero_next : count will be zero after this clock edge
module bp_credit_cnt
    import bp_pkg::*;
#(
    parameter int MAX_OUT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic avail,
    output logic zero,
    output logic zero_next
);

    localparam logic [CRED_W-1:0] MAX_C = CRED_W'(MAX_OUT);

    logic [CRED_W-1:0] cnt_reg;
    logic [CRED_W-1:0] cnt_next;

    // Simultaneous inc/dec cancel. A dec at zero is an underflow that the
    // parent flags; the count itself stays at zero rather than wrapping.
    always_comb begin
        cnt_next = cnt_reg;
        if (inc && !dec) begin
            cnt_next = cnt_reg + 1'b1;
        end else if (dec && !inc && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign avail     = (cnt_reg < MAX_C);
    assign zero      = (cnt_reg == '0);
    assign zero_next = (cnt_next == '0);

endmodule

// File: rtl/bp_rec_ctrl.sv
// BP block reconstruction controller. Accepts one block descriptor at a
// time and issues per-component/per-subblock reconstruction commands,
// limiting commands in flight to MAX_OUT, then waits for all completions.
//   clk, rst      : clock, synchronous active-high reset
//   bus (master)  : blk_* descriptor handshake, cmd_* command handshake, rec_done
//   lb_sel        : line-buffer bank being written; flips after every block
//   blk_done      : one-cycle pulse when a block is fully reconstructed
//   err_underflow : sticky; rec_done seen with nothing outstanding
module bp_rec_ctrl
    import bp_pkg::*;
#(
    parameter int MAX_OUT = 2
) (
    input  logic          clk,
    input  logic          rst,
    bp_rec_ctrl_if.master bus,
    output logic          lb_sel,
    output logic          blk_done,
    output logic          err_underflow
);

    state_t            state_reg;
    state_t            state_next;

    logic              skip_reg;
    logic [SB_NUM-1:0] use2x2_reg;
    logic [QP_W-1:0]   qp_reg;
    logic [CNT_W-1:0]  idx_reg;
    logic              lb_sel_reg;
    logic              err_reg;

    logic              cred_avail;
    logic              cred_zero;
    logic              cred_zero_next;

    logic              blk_fire;
    logic              cmd_fire;
    logic              last_cmd;
    logic [CNT_W-1:0]  last_idx;
    cmd_t              cur_cmd;

    assign blk_fire = bus.blk_valid && (state_reg == ST_IDLE) && !rst;
    assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
    assign last_idx = skip_reg ? CNT_W'(CMDS_SKIP - 1) : CNT_W'(CMDS_FULL - 1);
    assign last_cmd = (idx_reg == last_idx);
    assign cur_cmd  = cmd_fields(skip_reg, idx_reg, use2x2_reg);

    bp_credit_cnt #(
        .MAX_OUT (MAX_OUT)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .inc       (cmd_fire),
        .dec       (bus.rec_done),
        .avail     (cred_avail),
        .zero      (cred_zero),
        .zero_next (cred_zero_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. DRAIN looks at the post-edge count so blk_done
    // follows the final rec_done by exactly one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (blk_fire)             state_next = ST_ISSUE;
            ST_ISSUE: if (cmd_fire && last_cmd) state_next = ST_DRAIN;
            ST_DRAIN: if (cred_zero_next)       state_next = ST_DONE;
            ST_DONE:                            state_next = ST_IDLE;
            default:                            state_next = ST_IDLE;
        endcase
    end

    // Outputs. cmd_valid can only fall through an accept (the credit count
    // never rises without one), so an offered command holds until taken;
    // the fields come from registers that only move on accept.
    always_comb begin
        bus.blk_ready = (state_reg == ST_IDLE) && !rst;
        bus.cmd_valid = (state_reg == ST_ISSUE) && cred_avail;
        bus.cmd_comp  = cur_cmd.comp;
        bus.cmd_sb    = cur_cmd.sb;
        bus.cmd_2x2   = cur_cmd.part2x2;
        bus.cmd_skip  = cur_cmd.skip;
        bus.cmd_qp    = qp_reg;
        blk_done      = (state_reg == ST_DONE);
        lb_sel        = lb_sel_reg;
        err_underflow = err_reg;
    end

    // Block context, command index, bank select and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_reg   <= 1'b0;
            use2x2_reg <= '0;
            qp_reg     <= '0;
            idx_reg    <= '0;
            lb_sel_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            if (blk_fire) begin
                skip_reg   <= bus.blk_bpskip;
                use2x2_reg <= bus.blk_use2x2;
                qp_reg     <= bus.blk_qp;
                idx_reg    <= '0;
            end else if (cmd_fire && !last_cmd) begin
                idx_reg <= idx_reg + 1'b1;
            end
            if (state_reg == ST_DONE) begin
                lb_sel_reg <= ~lb_sel_reg;
            end
            if (bus.rec_done && cred_zero) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule
